// File: rtl/db15_joy_reader.sv
// db15_joy_reader
//   Serial reader for the DB15 joystick adapter. Drives the adapter's
//   shift-register chain with joy_clk / joy_load, shifts in 32 active-low
//   button bits and publishes two active-high 16-bit joystick words once per
//   frame. An all-zero frame is treated as a stuck/shorted data line and is
//   rejected (previous words are held, frame_err is raised).
//
// Parameters
//   CLK_DIV  clk cycles per half bit-period of joy_clk (3..255)
//   GAP      idle clk cycles between frames (1..65535)
//
// Ports
//   clk        in   core clock
//   reset_n    in   asynchronous active-low reset
//   joy_data   in   serial data from adapter, asynchronous, active-low
//   joy_clk    out  shift clock to adapter
//   joy_load   out  parallel-load strobe to adapter, active-low
//   joystick1  out  player 1 buttons, active-high
//   joystick2  out  player 2 buttons, active-high
//   frame_done out  one-cycle pulse on frame commit or reject
//   frame_err  out  1 when the last frame was rejected
module db15_joy_reader #(
  parameter int CLK_DIV = 8,
  parameter int GAP     = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        joy_data,
  output logic        joy_clk,
  output logic        joy_load,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        frame_done,
  output logic        frame_err
);

  localparam logic [15:0] GAP_LAST = 16'(GAP - 1);
  localparam logic [15:0] LOAD_LAST = 16'(2 * CLK_DIV - 1);
  localparam logic [15:0] BIT_LAST = 16'(2 * CLK_DIV - 1);
  localparam logic [15:0] LOW_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF = 16'(CLK_DIV);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0]  bit_q, bit_d;
  logic [31:0] raw_q, raw_d;
  logic [15:0] joy1_q, joy1_d;
  logic [15:0] joy2_q, joy2_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [1:0]  sync_q;

  // Two-flop synchronizer; resets to "released" (1) so a reset never looks
  // like a pressed button.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], joy_data};
    end
  end

  // State register and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      raw_q   <= '1;
      joy1_q  <= '0;
      joy2_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      raw_q   <= raw_d;
      joy1_q  <= joy1_d;
      joy2_q  <= joy2_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic. In SHIFT, cnt_q runs over one full bit-period:
  // 0..CLK_DIV-1 is the low half, CLK_DIV..2*CLK_DIV-1 the high half.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    raw_d   = raw_q;
    joy1_d  = joy1_q;
    joy2_d  = joy2_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_LOAD: begin
        if (cnt_q == LOAD_LAST) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_SHIFT: begin
        // Sample as late as possible in the low half so data shifted at the
        // previous rising edge has crossed the synchronizer.
        if (cnt_q == LOW_LAST) begin
          raw_d[bit_q] = sync_q[1];
        end
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (bit_q == 5'd31) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            // All-zero means a shorted/stuck-low line, not "everything pressed".
            if (raw_q == 32'h0) begin
              err_d = 1'b1;
            end else begin
              joy1_d = ~raw_q[15:0];
              joy2_d = ~raw_q[31:16];
              err_d  = 1'b0;
            end
          end else begin
            bit_d = bit_q + 5'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic; decoded from registered state so reset takes effect at once.
  always_comb begin
    joy_load   = (state_q != ST_LOAD);
    joy_clk    = (state_q == ST_SHIFT) && (cnt_q >= HALF);
    joystick1  = joy1_q;
    joystick2  = joy2_q;
    frame_done = done_q;
    frame_err  = err_q;
  end

endmodule

// File: doc/db15_joy_reader.md
# db15_joy_reader

Serial reader for the DB15 joystick adapter on the user port. It drives the adapter's shift-register chain with `joy_clk` and `joy_load`, shifts in 32 active-low button bits, and converts them to two active-high 16-bit joystick words. It sits directly upstream of the joystick-select muxing in `emu`. The words it produces replace the USB joystick words when the DB15 mode is selected in the OSD.

## Interface
- `CLK_DIV`, default 8: clk cycles per half bit-period of `joy_clk`. Legal range is 3..255.
- `GAP`, default 1024: idle clk cycles between frames. Legal range is 1..65535.

Ports:
- `clk`  in  1  core clock, 40-50 MHz (CLK_JOY). The block uses one clock.
- `reset_n`  in  1  reset, asynchronous and active-low. It resets every register.
- `joy_data`  in  1  serial data from the adapter, asynchronous, active-low (0 = pressed).
- `joy_clk`  out  1  shift clock to the adapter.
- `joy_load`  out  1  parallel-load strobe to the adapter, active-low.
- `joystick1`  out  16  player 1 buttons, active-high.
- `joystick2`  out  16  player 2 buttons, active-high.
- `frame_done`  out  1  one-cycle pulse when a frame is committed or rejected.
- `frame_err`  out  1  1 if the last frame was rejected.

## Operation
- `joy_data` is synchronized through two flops before it is used.
- The block has three states: IDLE, LOAD and SHIFT. Reset enters IDLE.
- **IDLE**
  - Outputs: `joy_clk`=0, `joy_load`=1.
  - Counts `GAP` cycles, then goes to LOAD.
- **LOAD**
  - Outputs: `joy_load`=0, `joy_clk`=0.
  - Lasts 2·`CLK_DIV` cycles, then goes to SHIFT with bit index k=0.
- **SHIFT**
  - One bit-period per index k=0..31: `joy_clk`=0 for `CLK_DIV` cycles, then `joy_clk`=1 for `CLK_DIV` cycles.
  - Sampling: the synchronized data is captured into raw[k] on the last clk cycle of the low half.
  - The adapter shifts on the rising edge of `joy_clk`.
  - After k=31 completes its high half, the block commits the frame and returns to IDLE.
- **Bit mapping**
  - `joystick1`[i] = ~raw[i] for i=0..15.
  - `joystick2`[i] = ~raw[16+i] for i=0..15.
  - Bit order from the adapter is `joystick1`[9:0] = FEDCBAUDLR, with [11:10] = L,S.
- **Commit**
  - A valid frame loads both joystick words in the same cycle, clears `frame_err` and pulses `frame_done`.
- **Reject**
  - A frame with raw == 32'h0 is rejected. This is the stuck-low/shorted-line case, which would otherwise read as every button pressed.
  - On reject, the joystick words hold their previous values, `frame_err` is set to 1 and `frame_done` pulses.
- The shift register is internal. Only the commit step updates the outputs, so intermediate bits never appear on the outputs.

## Timing
- Reset values: `joy_clk`=0, `joy_load`=1, `joystick1`=0, `joystick2`=0, `frame_done`=0, `frame_err`=0. The sync flops reset to 1 (released = not pressed).
- Frame period: `GAP` + 2·`CLK_DIV` + 64·`CLK_DIV` clk cycles. With the defaults this is 1024 + 16 + 512 = 1552 cycles.
- LOAD begins on the cycle after the `GAP`-th IDLE cycle.
- Capture latency: a `joy_data` level is visible to sampling 2 cycles after it arrives. `CLK_DIV` ≥ 3 guarantees that data shifted at a rising edge has settled before the next sample.
- The outputs and `frame_done` update on the clk edge that ends the k=31 high half. This is registered, with zero extra delay.
- `frame_done` stays high for exactly one cycle and is never asserted outside a commit or reject.
- Reset asserted mid-frame:
  - All outputs return to their reset values immediately (asynchronously).
  - The partial frame is discarded.
  - After `reset_n` is released, operation restarts with a full `GAP`.
- `joy_data` changing during the high half of `joy_clk` has no effect until the next sample point.

## Test plan
- **Reset:** hold `reset_n`=0, then release. Expect `joy_load`=1, `joy_clk`=0 and both joystick words 0. The first `joy_load` fall comes exactly `GAP` cycles after release. With `CLK_DIV`=4, `GAP`=16, this is cycle 16.
- **Frame shape** (`CLK_DIV`=4, `GAP`=16):
  - `joy_load` is low for 8 cycles.
  - Then 32 `joy_clk` pulses, each 4 low / 4 high.
  - `frame_done` at cycle 16+8+256.
  - The next `joy_load` fall comes 16 cycles later, giving a 280-cycle period.
- **Mapping:** a bench shift-register model presents raw = 32'hFFFE_FFFB. Expect `joystick1`=16'h0004, `joystick2`=16'h0001 and `frame_err`=0.
- **Reject:** model drives all 0s after a valid frame loaded 16'h0004/16'h0001. Expect the outputs unchanged, `frame_err`=1 and one `frame_done` pulse. The next frame of all 1s gives both words 16'h0000 and `frame_err`=0.
- **Mid-frame reset:** assert `reset_n`=0 at bit k=10. Expect immediate reset values and no `frame_done`. After release, the next commit carries the full new frame.
- **Sample point:** toggle `joy_data` only during the high halves. Expect the captured bits to reflect the low-half levels only.
